// File: rtl/ulpi_init_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ulpi_init_seq : programs (and optionally verifies) the ULPI PHY       |
// | register table after reset, reporting INIT_DONE / INIT_ERR.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ulpi_init_seq #(
  parameter int SETTLE_CYCLES = 16,
  parameter int TIMEOUT       = 255,
  parameter int MAX_RETRY     = 3,
  parameter bit VERIFY        = 1'b1
) (
  input  logic       CLK_60M,
  input  logic       NRST_A_USB,
  input  logic       START,
  input  logic       READY,
  input  logic       REG_DONE,
  input  logic       REG_FAIL,
  input  logic [7:0] REG_DATA_O,
  output logic       REG_EN,
  output logic       REG_RW,
  output logic [5:0] REG_ADDR,
  output logic [7:0] REG_DATA_I,
  output logic       INIT_DONE,
  output logic       INIT_ERR,
  output logic [1:0] ERR_IDX
);

  localparam logic [15:0] c_SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  c_TMO_LAST    = 8'(TIMEOUT - 1);
  localparam logic [7:0]  c_MAX_RETRY   = 8'(MAX_RETRY);
  localparam logic [1:0]  c_LAST_IDX    = 2'd2;

  typedef enum logic [2:0] {
    S_WAIT_READY = 3'd0,
    S_GAP        = 3'd1,
    S_WR         = 3'd2,
    S_RD         = 3'd3,
    S_NEXT       = 3'd4,
    S_DONE       = 3'd5,
    S_ERROR      = 3'd6
  } state_t;

  state_t      r_state;
  logic [15:0] r_settle;
  logic [1:0]  r_idx;
  logic [7:0]  r_retry;
  logic [7:0]  r_timer;
  logic        r_reg_en;
  logic        r_reg_rw;
  logic [5:0]  r_reg_addr;
  logic [7:0]  r_reg_data;
  logic        r_init_done;
  logic        r_init_err;
  logic [1:0]  r_err_idx;

  logic [5:0]  w_tbl_addr;
  logic [7:0]  w_tbl_data;
  logic        w_done_ok;
  logic        w_op_fail;
  logic        w_op_ok;

  always_comb begin
    w_tbl_addr = 6'h00;
    w_tbl_data = 8'h00;
    case (r_idx)
      2'd0: begin w_tbl_addr = 6'h04; w_tbl_data = 8'h45; end
      2'd1: w_tbl_addr = 6'h0A;
      2'd2: w_tbl_addr = 6'h07;
      default: ;
    endcase
  end

  // A response arriving on the last permitted cycle still counts as success.
  always_comb begin
    w_done_ok = r_reg_en && REG_DONE && !REG_FAIL &&
                ((r_state == S_WR) || (REG_DATA_O == w_tbl_data));
    w_op_fail = 1'b0;
    w_op_ok   = 1'b0;
    if ((r_state == S_WR) || (r_state == S_RD)) begin
      w_op_ok   = w_done_ok;
      w_op_fail = r_reg_en && !w_done_ok &&
                  (REG_FAIL || REG_DONE || (r_timer == c_TMO_LAST));
    end
  end

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      r_state     <= S_WAIT_READY;
      r_settle    <= 16'd0;
      r_idx       <= 2'd0;
      r_retry     <= 8'd0;
      r_timer     <= 8'd0;
      r_reg_en    <= 1'b0;
      r_reg_rw    <= 1'b0;
      r_reg_addr  <= 6'h00;
      r_reg_data  <= 8'h00;
      r_init_done <= 1'b0;
      r_init_err  <= 1'b0;
      r_err_idx   <= 2'd0;
    end else if ((r_state != S_WAIT_READY) && !READY) begin
      r_state     <= S_WAIT_READY;
      r_settle    <= 16'd0;
      r_idx       <= 2'd0;
      r_retry     <= 8'd0;
      r_reg_en    <= 1'b0;
      r_init_done <= 1'b0;
      r_init_err  <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT_READY: begin
          if (!READY) begin
            r_settle <= 16'd0;
          end else if (r_settle == c_SETTLE_LAST) begin
            r_settle <= 16'd0;
            r_state  <= S_GAP;
          end else begin
            r_settle <= r_settle + 16'd1;
          end
        end

        S_GAP: begin
          r_reg_en   <= 1'b1;
          r_reg_rw   <= 1'b1;
          r_reg_addr <= w_tbl_addr;
          r_reg_data <= w_tbl_data;
          r_timer    <= 8'd0;
          r_state    <= S_WR;
        end

        // Retry bookkeeping happens on the failing edge so that the only
        // REG_EN-low cycle before the re-issued write is the GAP cycle.
        S_WR, S_RD: begin
          if (w_op_fail) begin
            r_reg_en <= 1'b0;
            if (r_retry == c_MAX_RETRY) begin
              r_init_err <= 1'b1;
              r_err_idx  <= r_idx;
              r_state    <= S_ERROR;
            end else begin
              r_retry <= r_retry + 8'd1;
              r_state <= S_GAP;
            end
          end else if (w_op_ok) begin
            r_reg_en <= 1'b0;
            if ((r_state == S_WR) && VERIFY) begin
              r_reg_rw   <= 1'b0;
              r_reg_data <= 8'h00;
              r_timer    <= 8'd0;
              r_state    <= S_RD;
            end else begin
              r_state <= S_NEXT;
            end
          end else if (r_reg_en) begin
            r_timer <= r_timer + 8'd1;
          end else begin
            // Read is issued one idle cycle after the write completes.
            r_reg_en <= 1'b1;
            r_timer  <= 8'd0;
          end
        end

        S_NEXT: begin
          r_idx   <= r_idx + 2'd1;
          r_retry <= 8'd0;
          if (r_idx == c_LAST_IDX) begin
            r_init_done <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_state <= S_GAP;
          end
        end

        S_DONE: begin
          if (START) begin
            r_init_done <= 1'b0;
            r_idx       <= 2'd0;
            r_retry     <= 8'd0;
            r_state     <= S_GAP;
          end
        end

        S_ERROR: begin
          if (START) begin
            r_init_err <= 1'b0;
            r_idx      <= 2'd0;
            r_retry    <= 8'd0;
            r_state    <= S_GAP;
          end
        end

        default: r_state <= S_WAIT_READY;
      endcase
    end
  end

  assign REG_EN     = r_reg_en;
  assign REG_RW     = r_reg_rw;
  assign REG_ADDR   = r_reg_addr;
  assign REG_DATA_I = r_reg_data;
  assign INIT_DONE  = r_init_done;
  assign INIT_ERR   = r_init_err;
  assign ERR_IDX    = r_err_idx;

endmodule
`default_nettype wire
